pipelined_decode: RTL and testbench
===================================

Name: pipelined_decode

Overview:
Parametrised next-generation LEGv8 decode stage for the pipelined core, with one clock in place of split read/write clocks. Contains the IF/ID register, instruction field parse, control decode, sign extension, an N-entry register file with write-through bypass, load-use hazard detection with stall, branch flush, and a registered ID/EX output bundle. Sits between the fetch stage and the execute stage; the writeback stage drives its write port.

Parameters:
WORD, 64, datapath and register width in bits
INSTR_LEN, 32, instruction width in bits
REG_ADDR_W, 5, register address width; register count = 2**REG_ADDR_W
ZERO_REG, 31, index of hard-wired zero register (XZR)

Ports:
clk  input  1  single pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
if_valid  input  1  fetch presents a valid instruction
if_pc  input  WORD  PC of fetched instruction
if_instruction  input  INSTR_LEN  fetched instruction
flush  input  1  branch taken in EX/MEM; squash younger instructions
wb_reg_write  input  1  writeback enable
wb_write_reg  input  REG_ADDR_W  writeback destination
wb_write_data  input  WORD  writeback data
stall  output  1  combinational; fetch must hold PC and instruction
ex_valid  output  1  ID/EX bundle holds a real instruction
ex_pc  output  WORD  registered PC
ex_opcode  output  11  registered instruction[31:21]
ex_read_data1, ex_read_data2  output  WORD  registered operands (Rn, Rm-or-Rt)
ex_sign_ext  output  WORD  registered sign-extended immediate
ex_rn, ex_reg2, ex_rd  output  REG_ADDR_W  registered source/destination numbers
ex_reg2_loc, ex_uncondbranch, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  output  1  registered control
ex_alu_op  output  2  registered ALU op
ex_illegal  output  1  registered unrecognised-opcode flag

Behaviour:
- Reset (rst_n low, any time, asynchronous): IF/ID and ID/EX registers and all register-file entries cleared to 0; ex_valid=0, all ex_* outputs 0; stall=0 while in reset. Mid-operation reset discards in-flight instructions.
- Pipeline: rising edge N loads IF/ID from if_*; decode is combinational in cycle N..N+1; edge N+1 loads ID/EX. Latency 2 edges from if_* to ex_*.
- Field parse: rd/rt=[4:0], rn=[9:5], rm=[20:16]; reg2 = reg2_loc ? rt : rm.
- Control decode (opcode [31:21]): LDUR 11111000010 -> alu_src, mem_to_reg, reg_write, mem_read, alu_op 00. STUR 11111000000 -> reg2_loc, alu_src, mem_write, alu_op 00. ADD 10001011000 / SUB 11001011000 / AND 10001010000 / ORR 10101010000 -> reg_write, alu_op 10. CBZ 10110100xxx -> reg2_loc, branch, alu_op 01. B 000101xxxxx -> uncondbranch. Anything else: all controls 0, ex_illegal=1.
- Sign extension to WORD: LDUR/STUR imm9 [20:12]; CBZ imm19 [23:5]; B imm26 [25:0]; others 0.
- Register file: write on rising edge when wb_reg_write=1 and wb_write_reg!=ZERO_REG; writes to ZERO_REG ignored; reads of ZERO_REG return 0. Bypass: same-cycle read of the register being written returns wb_write_data (except ZERO_REG).
- Load-use hazard: stall=1 when IF/ID valid, ex_valid=1, ex_mem_read=1, ex_rd!=ZERO_REG, and ex_rd equals decoded rn or reg2 (reg2 checked only for R-type, STUR, CBZ; rn not checked for B/CBZ). On stall edge: IF/ID holds; ID/EX loads a bubble (ex_valid=0, all controls 0). Stall lasts exactly one cycle per load.
- Flush: at next edge, IF/ID valid=0 and ID/EX becomes bubble. Flush overrides stall; stall is forced 0 while flush=1.
- if_valid=0: IF/ID captures a bubble; bubbles propagate as ex_valid=0 with zero controls and never raise stall.

Test Plan:
- Reset then write X1=0x5 via WB; send ADD X3,X1,X2 (X2=0x7) -> 2 edges later ex_valid=1, ex_read_data1=5, ex_read_data2=7, ex_alu_op=10, ex_reg_write=1, ex_rd=3.
- WB writes X4=0xAA in same cycle LDUR X5,[X4,#-8] is in decode -> ex_read_data1=0xAA (bypass), ex_sign_ext=0xFFFF_FFFF_FFFF_FFF8, ex_mem_read=1.
- LDUR X2,[X1,#0] followed by ADD X3,X2,X2 -> stall=1 for one cycle, one bubble (ex_valid=0), ADD issues next cycle with IF/ID unchanged.
- WB write of 0x1234 to X31; then ORR X6,X31,X31 -> ex_read_data1=ex_read_data2=0; LDUR X31 then dependent ADD -> no stall.
- flush asserted with stall condition present -> stall=0; next edge ex_valid=0 and IF/ID invalid; CBZ X9,#-1 decodes ex_sign_ext=all ones, ex_branch=1, ex_reg2=9.
- Assert rst_n=0 mid-stream between edges -> ex_* immediately 0; opcode 0x000 after reset -> ex_illegal=1, controls 0.

Source files
------------

// File: rtl/pipelined_decode.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_decode
// Brief    : LEGv8 decode stage - IF/ID register, control decode, register file
//            with write-through bypass, load-use stall, flush, ID/EX register.
// Revision : 1.0
// ============================================================================
module pipelined_decode #(
  parameter int WORD       = 64,
  parameter int INSTR_LEN  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_if_valid,
  input  logic [WORD-1:0]       i_if_pc,
  input  logic [INSTR_LEN-1:0]  i_if_instruction,
  input  logic                  i_flush,
  input  logic                  i_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] i_wb_write_reg,
  input  logic [WORD-1:0]       i_wb_write_data,
  output logic                  o_stall,
  output logic                  o_ex_valid,
  output logic [WORD-1:0]       o_ex_pc,
  output logic [10:0]           o_ex_opcode,
  output logic [WORD-1:0]       o_ex_read_data1,
  output logic [WORD-1:0]       o_ex_read_data2,
  output logic [WORD-1:0]       o_ex_sign_ext,
  output logic [REG_ADDR_W-1:0] o_ex_rn,
  output logic [REG_ADDR_W-1:0] o_ex_reg2,
  output logic [REG_ADDR_W-1:0] o_ex_rd,
  output logic                  o_ex_reg2_loc,
  output logic                  o_ex_uncondbranch,
  output logic                  o_ex_branch,
  output logic                  o_ex_mem_read,
  output logic                  o_ex_mem_to_reg,
  output logic                  o_ex_mem_write,
  output logic                  o_ex_alu_src,
  output logic                  o_ex_reg_write,
  output logic [1:0]            o_ex_alu_op,
  output logic                  o_ex_illegal
);

  localparam int                  NREGS     = 2**REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] c_zero  = REG_ADDR_W'(ZERO_REG);
  localparam logic [10:0]         c_op_ldur = 11'b11111000010;
  localparam logic [10:0]         c_op_stur = 11'b11111000000;
  localparam logic [10:0]         c_op_add  = 11'b10001011000;
  localparam logic [10:0]         c_op_sub  = 11'b11001011000;
  localparam logic [10:0]         c_op_and  = 11'b10001010000;
  localparam logic [10:0]         c_op_orr  = 11'b10101010000;
  localparam logic [7:0]          c_op_cbz  = 8'b10110100;
  localparam logic [5:0]          c_op_b    = 6'b000101;

  typedef struct packed {
    logic                  valid;
    logic [WORD-1:0]       pc;
    logic [10:0]           opcode;
    logic [WORD-1:0]       rd1;
    logic [WORD-1:0]       rd2;
    logic [WORD-1:0]       sext;
    logic [REG_ADDR_W-1:0] rn;
    logic [REG_ADDR_W-1:0] reg2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg2_loc;
    logic                  uncond;
    logic                  branch;
    logic                  mem_read;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_write;
    logic [1:0]            alu_op;
    logic                  illegal;
  } ex_bundle_t;

  logic                  r_ifid_valid;
  logic [WORD-1:0]       r_ifid_pc;
  logic [INSTR_LEN-1:0]  r_ifid_instr;
  logic [WORD-1:0]       r_regs [NREGS];
  ex_bundle_t            r_ex;
  ex_bundle_t            w_dec;
  logic [10:0]           w_op;
  logic [REG_ADDR_W-1:0] w_rn, w_rm, w_rd;
  logic                  w_chk_rn, w_chk_r2, w_issue;

  assign w_op = r_ifid_instr[31:21];
  assign w_rd = REG_ADDR_W'(r_ifid_instr[4:0]);
  assign w_rn = REG_ADDR_W'(r_ifid_instr[9:5]);
  assign w_rm = REG_ADDR_W'(r_ifid_instr[20:16]);

  always_comb begin
    w_dec        = '0;
    w_chk_rn     = 1'b1;
    w_chk_r2     = 1'b0;
    w_dec.valid  = 1'b1;
    w_dec.pc     = r_ifid_pc;
    w_dec.opcode = w_op;
    if (w_op == c_op_ldur) begin
      w_dec.alu_src    = 1'b1;
      w_dec.mem_to_reg = 1'b1;
      w_dec.reg_write  = 1'b1;
      w_dec.mem_read   = 1'b1;
      w_dec.sext       = {{(WORD-9){r_ifid_instr[20]}}, r_ifid_instr[20:12]};
    end else if (w_op == c_op_stur) begin
      w_dec.reg2_loc  = 1'b1;
      w_dec.alu_src   = 1'b1;
      w_dec.mem_write = 1'b1;
      w_dec.sext      = {{(WORD-9){r_ifid_instr[20]}}, r_ifid_instr[20:12]};
      w_chk_r2        = 1'b1;
    end else if (w_op == c_op_add || w_op == c_op_sub || w_op == c_op_and || w_op == c_op_orr) begin
      w_dec.reg_write = 1'b1;
      w_dec.alu_op    = 2'b10;
      w_chk_r2        = 1'b1;
    end else if (w_op[10:3] == c_op_cbz) begin
      w_dec.reg2_loc = 1'b1;
      w_dec.branch   = 1'b1;
      w_dec.alu_op   = 2'b01;
      w_dec.sext     = {{(WORD-19){r_ifid_instr[23]}}, r_ifid_instr[23:5]};
      w_chk_rn       = 1'b0;
      w_chk_r2       = 1'b1;
    end else if (w_op[10:5] == c_op_b) begin
      w_dec.uncond = 1'b1;
      w_dec.sext   = {{(WORD-26){r_ifid_instr[25]}}, r_ifid_instr[25:0]};
      w_chk_rn     = 1'b0;
    end else begin
      w_dec.illegal = 1'b1;
    end
    w_dec.rn   = w_rn;
    w_dec.rd   = w_rd;
    w_dec.reg2 = w_dec.reg2_loc ? w_rd : w_rm;
    // Write-through: a register being written this cycle reads as the new value
    w_dec.rd1 = (w_rn == c_zero) ? '0 :
                (i_wb_reg_write && i_wb_write_reg == w_rn) ? i_wb_write_data : r_regs[w_rn];
    w_dec.rd2 = (w_dec.reg2 == c_zero) ? '0 :
                (i_wb_reg_write && i_wb_write_reg == w_dec.reg2) ? i_wb_write_data : r_regs[w_dec.reg2];
  end

  assign o_stall = !i_flush && r_ifid_valid && r_ex.valid && r_ex.mem_read && (r_ex.rd != c_zero) &&
                   ((w_chk_rn && r_ex.rd == w_rn) || (w_chk_r2 && r_ex.rd == w_dec.reg2));
  assign w_issue = r_ifid_valid && !i_flush && !o_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= '0;
    end else if (i_flush) begin
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= '0;
    end else if (!o_stall) begin
      r_ifid_valid <= i_if_valid;
      r_ifid_pc    <= i_if_valid ? i_if_pc : '0;
      r_ifid_instr <= i_if_valid ? i_if_instruction : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_wb_reg_write && i_wb_write_reg != c_zero) begin
      r_regs[i_wb_write_reg] <= i_wb_write_data;
    end
  end

  // Stall, flush and empty IF/ID all inject an all-zero bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ex <= '0;
    else        r_ex <= w_issue ? w_dec : '0;
  end

  assign o_ex_valid        = r_ex.valid;
  assign o_ex_pc           = r_ex.pc;
  assign o_ex_opcode       = r_ex.opcode;
  assign o_ex_read_data1   = r_ex.rd1;
  assign o_ex_read_data2   = r_ex.rd2;
  assign o_ex_sign_ext     = r_ex.sext;
  assign o_ex_rn           = r_ex.rn;
  assign o_ex_reg2         = r_ex.reg2;
  assign o_ex_rd           = r_ex.rd;
  assign o_ex_reg2_loc     = r_ex.reg2_loc;
  assign o_ex_uncondbranch = r_ex.uncond;
  assign o_ex_branch       = r_ex.branch;
  assign o_ex_mem_read     = r_ex.mem_read;
  assign o_ex_mem_to_reg   = r_ex.mem_to_reg;
  assign o_ex_mem_write    = r_ex.mem_write;
  assign o_ex_alu_src      = r_ex.alu_src;
  assign o_ex_reg_write    = r_ex.reg_write;
  assign o_ex_alu_op       = r_ex.alu_op;
  assign o_ex_illegal      = r_ex.illegal;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_decode
// Brief    : Directed scoreboard bench for the LEGv8 decode stage.
// Revision : 1.0
// ============================================================================
module tb_pipelined_decode;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [10:0] opcode;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] sext;
    logic [4:0]  rn;
    logic [4:0]  reg2;
    logic [4:0]  rd;
    logic [7:0]  ctl;   // reg2_loc,uncond,branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write
    logic [1:0]  alu_op;
    logic        illegal;
  } ex_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [7:0]  CTL_LD  = 8'b0001_1011;
  localparam logic [7:0]  CTL_R   = 8'b0000_0001;
  localparam logic [7:0]  CTL_CBZ = 8'b1010_0000;
  localparam logic [7:0]  CTL_B   = 8'b0100_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic        stall, ex_valid, reg2_loc, uncond, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, illegal;
  logic [63:0] ex_pc, rd1, rd2, sext;
  logic [10:0] opcode;
  logic [4:0]  rn, reg2, rd;
  logic [1:0]  alu_op;
  ex_t         act;

  ex_t   exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_decode dut (
    .clk(clk), .rst_n(rst_n), .i_if_valid(if_valid), .i_if_pc(if_pc), .i_if_instruction(if_instr),
    .i_flush(flush), .i_wb_reg_write(wb_en), .i_wb_write_reg(wb_reg), .i_wb_write_data(wb_data),
    .o_stall(stall), .o_ex_valid(ex_valid), .o_ex_pc(ex_pc), .o_ex_opcode(opcode),
    .o_ex_read_data1(rd1), .o_ex_read_data2(rd2), .o_ex_sign_ext(sext),
    .o_ex_rn(rn), .o_ex_reg2(reg2), .o_ex_rd(rd),
    .o_ex_reg2_loc(reg2_loc), .o_ex_uncondbranch(uncond), .o_ex_branch(branch),
    .o_ex_mem_read(mem_read), .o_ex_mem_to_reg(mem_to_reg), .o_ex_mem_write(mem_write),
    .o_ex_alu_src(alu_src), .o_ex_reg_write(reg_write), .o_ex_alu_op(alu_op), .o_ex_illegal(illegal)
  );

  assign act = {ex_valid, ex_pc, opcode, rd1, rd2, sext, rn, reg2, rd,
                {reg2_loc, uncond, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write},
                alu_op, illegal};

  function automatic ex_t mk(input logic [63:0] pc, input logic [10:0] op, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] se, input logic [4:0] n,
                             input logic [4:0] r2, input logic [4:0] d, input logic [7:0] c,
                             input logic [1:0] aop, input logic ill);
    ex_t e;
    e = {1'b1, pc, op, d1, d2, se, n, r2, d, c, aop, ill};
    return e;
  endfunction

  function automatic logic [31:0] r_type(input logic [10:0] op, input logic [4:0] rm, input logic [4:0] n, input logic [4:0] d);
    return {op, rm, 6'b0, n, d};
  endfunction

  function automatic logic [31:0] d_type(input logic [10:0] op, input logic [8:0] imm, input logic [4:0] n, input logic [4:0] t);
    return {op, imm, 2'b00, n, t};
  endfunction

  task automatic chk_ex(input ex_t e, input string tag);
    n_checks++;
    assert (act === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, act, e);
    end
  endtask

  task automatic chk_stall(input logic e, input string tag);
    n_checks++;
    assert (stall === e) else begin
      n_fail++;
      $error("FAIL %s: stall observed %b required %b", tag, stall, e);
    end
  endtask

  task automatic push(input ex_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) chk_ex(exp_q.pop_front(), tag_q.pop_front());
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins);
    if_valid = v;
    if_pc    = pc;
    if_instr = ins;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [63:0] d);
    wb_en   = en;
    wb_reg  = r;
    wb_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, '0);
    wb(1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_ex('0, "reset_ex");
    chk_stall(1'b0, "reset_stall");
    rst_n = 1'b1;
    push('0, "idle0");

    // Register writes, then a dependent-free ADD X3,X1,X2
    wb(1'b1, 5'd1, 64'h5);  push('0, "idle1"); tick();
    wb(1'b1, 5'd2, 64'h7);  push('0, "idle2"); tick();
    wb(1'b0, '0, '0);
    drive(1'b1, 64'h100, r_type(OP_ADD, 5'd2, 5'd1, 5'd3));
    push(mk(64'h100, OP_ADD, 64'h5, 64'h7, 64'h0, 5'd1, 5'd2, 5'd3, CTL_R, 2'b10, 1'b0), "add_x3");
    tick();

    // LDUR X5,[X4,#-8] with X4 written by WB in the same decode cycle
    drive(1'b1, 64'h104, d_type(OP_LDUR, 9'h1F8, 5'd4, 5'd5));
    push(mk(64'h104, OP_LDUR, 64'hAA, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 5'd4, 5'd31, 5'd5, CTL_LD, 2'b00, 1'b0), "ldur_bypass");
    tick();
    wb(1'b1, 5'd4, 64'hAA);
    drive(1'b0, '0, '0);
    push('0, "bubble_after_ldur");
    tick();

    // Load-use: LDUR X2,[X1,#0] then ADD X3,X2,X2
    wb(1'b0, '0, '0);
    drive(1'b1, 64'h200, d_type(OP_LDUR, 9'h0, 5'd1, 5'd2));
    push(mk(64'h200, OP_LDUR, 64'h5, 64'h0, 64'h0, 5'd1, 5'd0, 5'd2, CTL_LD, 2'b00, 1'b0), "ldur_x2");
    tick();
    drive(1'b1, 64'h204, r_type(OP_ADD, 5'd2, 5'd2, 5'd3));
    push('0, "stall_bubble");
    tick();
    chk_stall(1'b1, "load_use_stall");
    drive(1'b1, 64'h999, r_type(OP_ORR, 5'd9, 5'd9, 5'd9));
    push(mk(64'h204, OP_ADD, 64'h7, 64'h7, 64'h0, 5'd2, 5'd2, 5'd3, CTL_R, 2'b10, 1'b0), "add_after_stall");
    tick();
    chk_stall(1'b0, "stall_one_cycle");

    // XZR: write ignored, reads zero, no stall on LDUR X31
    wb(1'b1, 5'd31, 64'h1234);
    drive(1'b0, '0, '0);
    push('0, "bubble_xzr_wb");
    tick();
    wb(1'b0, '0, '0);
    drive(1'b1, 64'h300, r_type(OP_ORR, 5'd31, 5'd31, 5'd6));
    push(mk(64'h300, OP_ORR, 64'h0, 64'h0, 64'h0, 5'd31, 5'd31, 5'd6, CTL_R, 2'b10, 1'b0), "orr_xzr");
    tick();
    drive(1'b1, 64'h304, d_type(OP_LDUR, 9'h0, 5'd1, 5'd31));
    push(mk(64'h304, OP_LDUR, 64'h5, 64'h0, 64'h0, 5'd1, 5'd0, 5'd31, CTL_LD, 2'b00, 1'b0), "ldur_xzr");
    tick();
    drive(1'b1, 64'h308, r_type(OP_ADD, 5'd31, 5'd31, 5'd3));
    push(mk(64'h308, OP_ADD, 64'h0, 64'h0, 64'h0, 5'd31, 5'd31, 5'd3, CTL_R, 2'b10, 1'b0), "add_xzr");
    tick();
    chk_stall(1'b0, "xzr_no_stall");

    // Flush overriding a pending load-use stall
    drive(1'b1, 64'h400, d_type(OP_LDUR, 9'h0, 5'd1, 5'd7));
    push(mk(64'h400, OP_LDUR, 64'h5, 64'h0, 64'h0, 5'd1, 5'd0, 5'd7, CTL_LD, 2'b00, 1'b0), "ldur_x7");
    tick();
    drive(1'b1, 64'h404, r_type(OP_ADD, 5'd7, 5'd7, 5'd8));
    push('0, "flush_bubble");
    tick();
    chk_stall(1'b1, "pre_flush_stall");
    flush = 1'b1;
    drive(1'b1, 64'h500, r_type(OP_ADD, 5'd1, 5'd1, 5'd1));
    #1;
    chk_stall(1'b0, "flush_forces_no_stall");
    push('0, "flushed_ifid");
    tick();
    flush = 1'b0;

    // CBZ X9,#-1 and B #-2
    drive(1'b1, 64'h600, {8'b10110100, 19'h7FFFF, 5'd9});
    push(mk(64'h600, 11'h5A7, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd9, 5'd9, CTL_CBZ, 2'b01, 1'b0), "cbz");
    tick();
    drive(1'b1, 64'h604, {6'b000101, 26'h3FF_FFFE});
    push(mk(64'h604, 11'h0BF, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 5'd31, 5'd31, 5'd30, CTL_B, 2'b00, 1'b0), "b");
    tick();
    drive(1'b1, 64'h800, r_type(OP_ADD, 5'd2, 5'd1, 5'd3));
    push(mk(64'h800, OP_ADD, 64'h5, 64'h7, 64'h0, 5'd1, 5'd2, 5'd3, CTL_R, 2'b10, 1'b0), "lost_add");
    tick();

    // Asynchronous reset between edges discards in-flight work
    #2;
    rst_n = 1'b0;
    #1;
    chk_ex('0, "async_reset_ex");
    chk_stall(1'b0, "async_reset_stall");
    exp_q.delete();
    tag_q.delete();
    drive(1'b0, '0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push('0, "post_reset_idle");
    drive(1'b1, 64'h900, 32'h0);
    push(mk(64'h900, 11'h000, 64'h0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0, 8'h00, 2'b00, 1'b1), "illegal_zero");
    tick();
    drive(1'b1, 64'h904, r_type(OP_ADD, 5'd2, 5'd1, 5'd3));
    push(mk(64'h904, OP_ADD, 64'h0, 64'h0, 64'h0, 5'd1, 5'd2, 5'd3, CTL_R, 2'b10, 1'b0), "add_regs_cleared");
    tick();
    drive(1'b0, '0, '0);
    push('0, "tail_bubble");
    tick();
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
